// File: rtl/mmio_gpio_slot.sv
// ============================================================================
// mmio_gpio_slot : GPIO peripheral on one MMIO slot with edge interrupts
// Revision 1.0
// ============================================================================
`default_nettype none

module mmio_gpio_slot #(
  parameter int GPIO_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  aclk,
  input  logic                  arst_n,
  input  logic                  chip_select,
  input  logic                  read,
  input  logic                  write,
  input  logic [7:0]            reg_addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic                  idle,
  output logic                  slave_error,
  output logic                  decode_error,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [7:0] ADDR_DATA_OUT = 8'h00;
  localparam logic [7:0] ADDR_DIR      = 8'h04;
  localparam logic [7:0] ADDR_DATA_IN  = 8'h08;
  localparam logic [7:0] ADDR_INT_EN   = 8'h0C;
  localparam logic [7:0] ADDR_INT_STAT = 8'h10;
  localparam logic [7:0] ADDR_EDGE_SEL = 8'h14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESP    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [GPIO_WIDTH-1:0] data_out, dir, int_en, int_stat, edge_sel;
  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] data_in, data_in_prev, edge_hits, clr_mask;
  logic                  accept, dec_err, slv_err, wr_en, rd_only;
  logic [31:0]           rd_mux;
  logic                  unused_wr_data;

  // Upper write-data bits are dropped for narrow configurations.
  assign unused_wr_data = ^wr_data;

  assign data_in   = sync_q[SYNC_STAGES-1];
  assign gpio_out  = data_out;
  assign gpio_oe   = dir;
  assign idle      = (state == ST_IDLE);

  assign accept    = (state == ST_IDLE) && chip_select && (read || write);
  assign dec_err   = (reg_addr[1:0] != 2'b00) || (reg_addr > ADDR_EDGE_SEL);
  assign slv_err   = !dec_err && ((read && write) || (write && reg_addr == ADDR_DATA_IN));
  assign rd_only   = read && !write;
  assign wr_en     = accept && write && !read && !dec_err && (reg_addr != ADDR_DATA_IN);

  assign edge_hits = (edge_sel & ~data_in & data_in_prev) | (~edge_sel & data_in & ~data_in_prev);
  assign clr_mask  = (wr_en && reg_addr == ADDR_INT_STAT) ? wr_data[GPIO_WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_DATA_OUT: rd_mux[GPIO_WIDTH-1:0] = data_out;
      ADDR_DIR:      rd_mux[GPIO_WIDTH-1:0] = dir;
      ADDR_DATA_IN:  rd_mux[GPIO_WIDTH-1:0] = data_in;
      ADDR_INT_EN:   rd_mux[GPIO_WIDTH-1:0] = int_en;
      ADDR_INT_STAT: rd_mux[GPIO_WIDTH-1:0] = int_stat;
      ADDR_EDGE_SEL: rd_mux[GPIO_WIDTH-1:0] = edge_sel;
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_RELEASE;
      ST_RELEASE: if (!chip_select) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      data_in_prev <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      data_in_prev <= data_in;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      data_out <= '0;
      dir      <= '0;
      int_en   <= '0;
      edge_sel <= '0;
      int_stat <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_addr)
          ADDR_DATA_OUT: data_out <= wr_data[GPIO_WIDTH-1:0];
          ADDR_DIR:      dir      <= wr_data[GPIO_WIDTH-1:0];
          ADDR_INT_EN:   int_en   <= wr_data[GPIO_WIDTH-1:0];
          ADDR_EDGE_SEL: edge_sel <= wr_data[GPIO_WIDTH-1:0];
          default:       ;
        endcase
      end
      // Edge set is OR-ed after the clear so a coincident edge wins.
      int_stat <= (int_stat & ~clr_mask) | edge_hits;
      irq      <= |(int_stat & int_en);
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      wr_done      <= 1'b0;
      rd_done      <= 1'b0;
      slave_error  <= 1'b0;
      decode_error <= 1'b0;
      rd_data      <= '0;
    end else begin
      wr_done      <= accept && write;
      rd_done      <= accept && rd_only;
      slave_error  <= accept && slv_err;
      decode_error <= accept && dec_err;
      if (accept && rd_only) rd_data <= dec_err ? 32'h0 : rd_mux;
    end
  end

endmodule

`default_nettype wire
